// File: rtl/usr_pkg.sv
// Shared types and defaults for the universal shift register
// serial receive path.
package usr_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } dir_e;

  typedef enum logic {
    IDLE,
    SHIFT
  } rx_state_e;

  localparam int USR_WIDTH = 4;

endpackage

// File: rtl/usr_hold_reg.sv
// One-entry valid/ready holding register with
// load-while-drain and sticky overflow on a dropped load.
module usr_hold_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             overflow
);

  logic accept;
  logic room;

  assign accept = valid & ready;
  assign room   = ~valid | accept;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      dout     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else if (load && room) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (load) begin
      // full and not draining: keep the old word, drop the new one
      overflow <= 1'b1;
    end else if (accept) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/usr_deserializer.sv
// Serial-to-parallel receiver: collects WIDTH qualified bits
// per frame and hands each word to a valid/ready holding register.
module usr_deserializer
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             SERIN,
  input  logic             SERVALID,
  input  logic             DIR,
  input  logic             CLEAR,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             DOUTVALID,
  input  logic             DOUTREADY,
  output logic             BUSY,
  output logic             OVERFLOW
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rx_state_e state, state_n;
  dir_e dir_q, dir_n, dir_eff;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sr, sr_n, sr_shift;
  logic done;

  // the first bit of a frame uses the live DIR; later bits the latch
  assign dir_eff = (state == IDLE) ? dir_e'(DIR) : dir_q;

  always_comb begin
    if (dir_eff == MSB_FIRST) sr_shift = {sr[WIDTH-2:0], SERIN};
    else                      sr_shift = {SERIN, sr[WIDTH-1:1]};
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    dir_n   = dir_q;
    done    = 1'b0;
    if (SERVALID) begin
      sr_n = sr_shift;
      unique case (state)
        IDLE: begin
          dir_n   = dir_e'(DIR);
          cnt_n   = CW'(1);
          state_n = SHIFT;
        end
        SHIFT: begin
          if (cnt == LAST) begin
            cnt_n   = '0;
            state_n = IDLE;
            done    = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      dir_q <= LSB_FIRST;
    end else if (CLEAR) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      dir_q <= LSB_FIRST;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sr    <= sr_n;
      dir_q <= dir_n;
    end
  end

  assign BUSY = (cnt != '0);

  usr_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clock   (clock),
    .reset   (reset),
    .clear   (CLEAR),
    .load    (done),
    .din     (sr_n),
    .ready   (DOUTREADY),
    .dout    (DATAOUT),
    .valid   (DOUTVALID),
    .overflow(OVERFLOW)
  );

endmodule

// File: tb/tb_usr_deserializer.sv
// Self-checking bench: frame-level reference model plus
// directed cases and randomized traffic.
module tb_usr_deserializer;

  localparam int W = 4;

  logic clock, reset;
  logic SERIN, SERVALID, DIR, CLEAR, DOUTREADY;
  logic [W-1:0] DATAOUT;
  logic DOUTVALID, BUSY, OVERFLOW;

  int total = 0;
  int bad = 0;

  usr_deserializer #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .SERIN    (SERIN),
    .SERVALID (SERVALID),
    .DIR      (DIR),
    .CLEAR    (CLEAR),
    .DATAOUT  (DATAOUT),
    .DOUTVALID(DOUTVALID),
    .DOUTREADY(DOUTREADY),
    .BUSY     (BUSY),
    .OVERFLOW (OVERFLOW)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // frame model: bits in arrival order, word assembled by position
  bit           mb[W];
  int           mcnt = 0;
  bit           mdir = 0;
  logic [W-1:0] mdata = '0;
  bit           mvalid = 0;
  bit           movf = 0;

  always @(posedge clock) begin
    logic [W-1:0] word;
    bit cons, fin;
    word = '0;
    fin  = 0;
    cons = 0;
    if (!reset || CLEAR) begin
      mcnt = 0; mvalid = 0; movf = 0; mdata = '0;
    end else begin
      cons = mvalid && DOUTREADY;
      if (SERVALID) begin
        if (mcnt == 0) mdir = DIR;
        mb[mcnt] = SERIN;
        mcnt++;
        if (mcnt == W) begin
          fin  = 1;
          mcnt = 0;
          for (int i = 0; i < W; i++)
            word[mdir ? (W - 1 - i) : i] = mb[i];
        end
      end
      if (fin && (!mvalid || cons)) begin
        mdata  = word;
        mvalid = 1;
      end else begin
        if (fin) movf = 1;
        if (cons) mvalid = 0;
      end
    end
    #1;
    check("m_valid", DOUTVALID, mvalid);
    check("m_busy", BUSY, mcnt != 0);
    check("m_ovf", OVERFLOW, movf);
    if (mvalid) check("m_data", DATAOUT, mdata);
  end

  task automatic sbit(input logic b, input logic d, input int gap);
    SERVALID = 1'b1; SERIN = b; DIR = d;
    @(negedge clock);
    SERVALID = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  // seq is written in time order, leftmost bit first
  task automatic frame(input logic [W-1:0] seq, input logic d);
    for (int i = 0; i < W; i++) sbit(seq[W-1-i], d, 0);
  endtask

  initial begin
    reset = 1'b1; SERIN = 0; SERVALID = 0; DIR = 0;
    CLEAR = 0; DOUTREADY = 1;
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_valid", DOUTVALID, 0);
    check("rst_data", DATAOUT, 0);
    check("rst_busy", BUSY, 0);
    check("rst_ovf", OVERFLOW, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // MSB-first, one-cycle valid pulse
    frame(4'b1011, 1'b1);
    check("t1_valid", DOUTVALID, 1);
    check("t1_data", DATAOUT, 4'b1011);
    @(negedge clock);
    check("t1_pulse", DOUTVALID, 0);

    // LSB-first
    frame(4'b1011, 1'b0);
    check("t2_data", DATAOUT, 4'b1101);
    @(negedge clock);

    // gaps and DIR toggling mid-frame
    sbit(1, 1, 2);
    check("t3_busy", BUSY, 1);
    sbit(0, 0, 3);
    sbit(1, 0, 0);
    check("t3_busy2", BUSY, 1);
    sbit(1, 0, 0);
    check("t3_data", DATAOUT, 4'b1011);
    check("t3_idle", BUSY, 0);
    @(negedge clock);

    // back-pressure and overflow
    DOUTREADY = 0;
    frame(4'b0101, 1'b0);
    frame(4'b1010, 1'b0);
    check("t4_data", DATAOUT, 4'hA);
    check("t4_ovf", OVERFLOW, 1);
    DOUTREADY = 1;
    @(negedge clock);
    check("t4_drain", DOUTVALID, 0);
    check("t4_sticky", OVERFLOW, 1);
    CLEAR = 1;
    @(negedge clock);
    CLEAR = 0;
    check("t4_clr", OVERFLOW, 0);

    // back-to-back frames
    frame(4'b1100, 1'b1);
    check("t5_w1", DATAOUT, 4'b1100);
    frame(4'b0011, 1'b1);
    check("t5_w2", DATAOUT, 4'b0011);
    check("t5_ovf", OVERFLOW, 0);
    @(negedge clock);

    // async reset mid-frame
    sbit(1, 1, 0);
    sbit(1, 1, 0);
    #2 reset = 1'b0;
    #1;
    check("t6_rbusy", BUSY, 0);
    @(negedge clock);
    reset = 1'b1;
    frame(4'b0110, 1'b1);
    check("t6_data", DATAOUT, 4'b0110);
    sbit(1, 1, 0);
    check("t6_part", BUSY, 1);
    SERVALID = 1; SERIN = 1; CLEAR = 1;
    @(negedge clock);
    SERVALID = 0; CLEAR = 0;
    check("t6_clr", BUSY, 0);
    check("t6_clrv", DOUTVALID, 0);

    // randomized traffic
    repeat (600) begin
      SERVALID  = ($urandom_range(0, 3) != 0);
      SERIN     = 1'($urandom);
      DIR       = 1'($urandom);
      DOUTREADY = ($urandom_range(0, 2) != 0);
      CLEAR     = ($urandom_range(0, 60) == 0);
      reset     = ($urandom_range(0, 150) != 0);
      @(negedge clock);
    end
    reset = 1; SERVALID = 0; CLEAR = 0;
    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
